acumulador_parametrico: RTL and testbench
=========================================

Name: acumulador_parametrico

Overview:
- Parametrised successor of the selective-adder + feedback accumulator pair, merged into one pipelined block.
- Two operands are combined per a select code, then accumulated.
- Adds:
  - valid qualification;
  - a 2-stage pipeline;
  - run-time choice of wrap or saturate;
  - sticky overflow;
  - synchronous clear;
  - an accepted-sample counter.
- Sits between VIO/ILA-driven stimulus and the top level's debug probes.

Parameters:
- NB_DATA, 3, width of each unsigned input operand.
- NB_ACC, 6, width of the unsigned accumulator. Must be >= NB_DATA+2.
- NB_CNT, 8, width of the accepted-sample counter.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_clear  in  1  synchronous clear of accumulator, overflow, counter and pipeline.
- i_valid  in  1  qualifies i_data1/i_data2/i_sel/i_mode_sat this cycle.
- i_data1  in  NB_DATA  operand 1, unsigned.
- i_data2  in  NB_DATA  operand 2, unsigned.
- i_sel  in  2  operand select: 00 d1+d2, 01 d1, 10 d2, 11 zero.
- i_mode_sat  in  1  1 = saturate on overflow, 0 = wrap on overflow.
- o_data  out  NB_ACC  accumulator value.
- o_overflow  out  1  sticky overflow flag.
- o_valid  out  1  one-cycle pulse: o_data updated by an accepted sample.
- o_count  out  NB_CNT  number of accepted samples, saturating.

Behaviour:
- Reset (i_rst=1, async): o_data=0, o_overflow=0, o_valid=0, o_count=0, stage-1 valid=0. Held while i_rst=1.
- Stage 1, on i_valid=1:
  - Register the operand, NB_DATA+1 bits, zero-extended: 00 -> d1+d2 (max 2*(2^NB_DATA-1)), 01 -> d1, 10 -> d2, 11 -> 0.
  - Register i_mode_sat together with the operand, so a mode change applies per sample.
  - Stage-1 valid = i_valid.
- Stage 2, when stage-1 valid=1:
  - sum = o_data + operand, computed in NB_ACC+1 bits.
  - If sum[NB_ACC]=0: o_data <= sum[NB_ACC-1:0].
  - If sum[NB_ACC]=1 and mode_sat=0: o_data <= sum[NB_ACC-1:0] (wrap); o_overflow <= 1.
  - If sum[NB_ACC]=1 and mode_sat=1: o_data <= all ones; o_overflow <= 1.
  - In saturate mode an exact landing on all ones (no carry) does not set o_overflow.
  - o_count increments by 1 and holds at 2^NB_CNT-1.
  - o_valid <= 1 for exactly one cycle.
- Latency: sample in at cycle N -> o_data/o_valid/o_count updated at the edge ending cycle N+1 (o_valid high in cycle N+2).
- Throughput: one sample per cycle; back-to-back i_valid fully supported, with no stall and no backpressure.
- Sel=11 is an accepted sample: counted, o_valid pulses, o_data unchanged.
- o_overflow is sticky: cleared only by i_rst or i_clear, never by later non-overflowing samples.
- i_clear=1 (sync, highest priority after reset):
  - Next edge: o_data=0, o_overflow=0, o_count=0, o_valid=0, stage-1 valid=0.
  - The in-flight stage-1 sample is discarded.
  - An i_valid asserted in the same cycle as i_clear is ignored.
- i_valid=0 cycles: all state holds; o_valid=0.
- Async reset mid-operation: the pipeline is flushed immediately; no o_valid pulse for the in-flight sample after reset release.
- Inputs are only sampled when i_valid=1; values on idle cycles have no effect.

Test Plan:
- Reset, then i_valid with sel=00, d1=3, d2=2, wrap -> two edges later o_data=5, o_valid one pulse, o_count=1, o_overflow=0.
- Five back-to-back samples sel=00, d1=7, d2=7, wrap -> o_data 14, 28, 42, 56, then 6 (70 mod 64); o_overflow=1 from the 5th update; o_count=5; o_valid high 5 consecutive cycles.
- Same five samples with i_mode_sat=1 -> o_data 14, 28, 42, 56, 63; o_overflow=1; a further sel=01, d1=1 sample keeps o_data=63.
- Accumulate to o_data=60, then sel=10, d2=3, sat -> o_data=63 with o_overflow=0; next sel=11 -> o_data=63, o_count increments, o_valid pulses.
- i_valid and i_clear together while a sample sits in stage 1 and o_data=42, o_overflow=1 -> next edge o_data=0, o_overflow=0, o_count=0, and no o_valid on the following cycle.
- 260 consecutive sel=11 samples (NB_CNT=8) -> o_count stops at 255; assert i_rst mid-burst -> all outputs 0 immediately (asynchronously), and no o_valid pulse after release.

Source files
------------

// File: rtl/acumulador_parametrico.sv
// acumulador_parametrico
// Selective adder followed by a feedback accumulator, in two pipeline stages.
// Stage 1 registers the selected operand together with its overflow mode.
// Stage 2 adds it into the accumulator, either wrapping or saturating.
// Stage 2 also keeps a sticky overflow flag, a one-cycle result strobe and
// a saturating count of accepted samples.
// NB_ACC must be at least NB_DATA+2 so that a single operand can never
// exceed the accumulator range on its own.
module acumulador_parametrico #(
   parameter int NB_DATA = 3,
   parameter int NB_ACC  = 6,
   parameter int NB_CNT  = 8
) (
   input  logic              clock,
   input  logic              i_rst,
   input  logic              i_clear,
   input  logic              i_valid,
   input  logic [NB_DATA-1:0] i_data1,
   input  logic [NB_DATA-1:0] i_data2,
   input  logic [1:0]        i_sel,
   input  logic              i_mode_sat,
   output logic [NB_ACC-1:0] o_data,
   output logic              o_overflow,
   output logic              o_valid,
   output logic [NB_CNT-1:0] o_count
);

   localparam logic [1:0] SEL_SUM  = 2'b00;
   localparam logic [1:0] SEL_D1   = 2'b01;
   localparam logic [1:0] SEL_D2   = 2'b10;

   logic [NB_DATA:0]  operand_next;
   logic [NB_DATA:0]  s1_operand;
   logic              s1_mode_sat;
   logic              s1_valid;
   logic [NB_ACC:0]   sum;

   // Operand selection; sel=11 contributes nothing but still counts as a sample.
   always_comb begin
      operand_next = '0;
      case (i_sel)
         SEL_SUM: operand_next = {1'b0, i_data1} + {1'b0, i_data2};
         SEL_D1:  operand_next = {1'b0, i_data1};
         SEL_D2:  operand_next = {1'b0, i_data2};
         default: operand_next = '0;
      endcase
   end

   // Stage 1: capture the operand and its mode only for qualified samples.
   always_ff @(posedge clock or posedge i_rst) begin
      if (i_rst) begin
         s1_valid    <= 1'b0;
         s1_operand  <= '0;
         s1_mode_sat <= 1'b0;
      end else if (i_clear) begin
         s1_valid    <= 1'b0;
      end else begin
         s1_valid <= i_valid;
         if (i_valid) begin
            s1_operand  <= operand_next;
            s1_mode_sat <= i_mode_sat;
         end
      end
   end

   // One extra bit so the carry out of the accumulator is visible.
   always_comb begin
      sum = {1'b0, o_data} + {{(NB_ACC-NB_DATA){1'b0}}, s1_operand};
   end

   // Stage 2: accumulate, flag overflow, count samples and strobe the result.
   always_ff @(posedge clock or posedge i_rst) begin
      if (i_rst) begin
         o_data     <= '0;
         o_overflow <= 1'b0;
         o_valid    <= 1'b0;
         o_count    <= '0;
      end else if (i_clear) begin
         o_data     <= '0;
         o_overflow <= 1'b0;
         o_valid    <= 1'b0;
         o_count    <= '0;
      end else begin
         o_valid <= s1_valid;
         if (s1_valid) begin
            if (sum[NB_ACC]) begin
               o_overflow <= 1'b1;
               o_data     <= s1_mode_sat ? '1 : sum[NB_ACC-1:0];
            end else begin
               o_data     <= sum[NB_ACC-1:0];
            end
            if (o_count != '1)
               o_count <= o_count + NB_CNT'(1);
         end
      end
   end

endmodule

// File: tb/tb_acumulador_parametrico.sv
// Bench for acumulador_parametrico: directed scenarios and a random run.
// Expected values come from an integer model of the accumulator.
// Accepted samples sit in a queue for one edge before being applied.
module tb_acumulador_parametrico;

   localparam int NB_DATA = 3;
   localparam int NB_ACC  = 6;
   localparam int NB_CNT  = 8;
   localparam int ACC_MAX = (1 << NB_ACC) - 1;
   localparam int CNT_MAX = (1 << NB_CNT) - 1;
   localparam int NB_ALL  = NB_ACC + NB_CNT + 2;

   logic              clock;
   logic              i_rst;
   logic              i_clear;
   logic              i_valid;
   logic [NB_DATA-1:0] i_data1;
   logic [NB_DATA-1:0] i_data2;
   logic [1:0]        i_sel;
   logic              i_mode_sat;
   logic [NB_ACC-1:0] o_data;
   logic              o_overflow;
   logic              o_valid;
   logic [NB_CNT-1:0] o_count;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int op;
      bit sat;
   } samp_t;

   samp_t q[$];
   int    m_acc;
   bit    m_ov;
   int    m_cnt;
   bit    m_vld;

   logic [NB_ALL-1:0] got;
   logic [NB_ALL-1:0] exp_v;

   acumulador_parametrico #(
      .NB_DATA(NB_DATA),
      .NB_ACC (NB_ACC),
      .NB_CNT (NB_CNT)
   ) dut (
      .clock     (clock),
      .i_rst     (i_rst),
      .i_clear   (i_clear),
      .i_valid   (i_valid),
      .i_data1   (i_data1),
      .i_data2   (i_data2),
      .i_sel     (i_sel),
      .i_mode_sat(i_mode_sat),
      .o_data    (o_data),
      .o_overflow(o_overflow),
      .o_valid   (o_valid),
      .o_count   (o_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic int op_of(input logic [1:0] s, input int a, input int b);
      case (s)
         2'd0: return a + b;
         2'd1: return a;
         2'd2: return b;
         default: return 0;
      endcase
   endfunction

   function automatic logic [NB_ALL-1:0] model_out();
      return {NB_ACC'(m_acc), m_ov, NB_CNT'(m_cnt), m_vld};
   endfunction

   task automatic model_reset();
      q.delete();
      m_acc = 0;
      m_ov  = 0;
      m_cnt = 0;
      m_vld = 0;
   endtask

   // Advance one clock edge, update the model, then settle 1 time unit past the edge.
   task automatic tick();
      samp_t s;
      @(posedge clock);
      if (i_clear) begin
         model_reset();
      end else begin
         m_vld = 0;
         if (q.size() > 0) begin
            s = q.pop_front();
            m_acc = m_acc + s.op;
            if (m_acc > ACC_MAX) begin
               m_ov  = 1;
               m_acc = s.sat ? ACC_MAX : m_acc - (ACC_MAX + 1);
            end
            m_vld = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
         end
         if (i_valid) begin
            s.op  = op_of(i_sel, int'(i_data1), int'(i_data2));
            s.sat = i_mode_sat;
            q.push_back(s);
         end
      end
      #1;
   endtask

   task automatic drive(input bit v, input logic [1:0] s, input int a, input int b, input bit sat);
      i_valid    = v;
      i_sel      = s;
      i_data1    = NB_DATA'(a);
      i_data2    = NB_DATA'(b);
      i_mode_sat = sat;
   endtask

   task automatic do_clear();
      drive(0, 2'd0, 0, 0, 0);
      i_clear = 1;
      tick();
      i_clear = 0;
   endtask

   task automatic test_reset();
      i_rst = 1; i_clear = 0;
      drive(1, 2'd0, 7, 7, 0);
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if ({o_data, o_overflow, o_count, o_valid} !== '0) begin
         failures++;
         $display("FAIL reset_held: data=%0d ovf=%0b cnt=%0d vld=%0b expected all zero", o_data, o_overflow, o_count, o_valid);
      end
      drive(0, 2'd0, 0, 0, 0);
      i_rst = 0;
      model_reset();
      tick();
      checks++;
      if ({o_data, o_overflow, o_count, o_valid} !== '0) begin
         failures++;
         $display("FAIL reset_release: data=%0d ovf=%0b cnt=%0d vld=%0b expected all zero", o_data, o_overflow, o_count, o_valid);
      end
   endtask

   task automatic test_single();
      do_clear();
      drive(1, 2'd0, 3, 2, 0);
      tick();
      drive(0, 2'd0, 0, 0, 0);
      checks++;
      if (o_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_latency: vld=%0b expected 0", o_valid);
      end
      tick();
      got = {o_data, o_overflow, o_count, o_valid};
      checks++;
      if (got !== {6'd5, 1'b0, 8'd1, 1'b1} || got !== model_out()) begin
         failures++;
         $display("FAIL single_result: data=%0d ovf=%0b cnt=%0d vld=%0b expected data=5 ovf=0 cnt=1 vld=1", o_data, o_overflow, o_count, o_valid);
      end
      tick();
      checks++;
      if (o_valid !== 1'b0 || o_data !== 6'd5) begin
         failures++;
         $display("FAIL single_pulse: data=%0d vld=%0b expected data=5 vld=0", o_data, o_valid);
      end
   endtask

   // Five 7+7 samples back to back; the fifth carries out of the accumulator.
   task automatic test_back_to_back(input bit sat);
      int expd[5];
      expd = '{14, 28, 42, 56, sat ? 63 : 6};
      do_clear();
      for (int i = 0; i < 7; i++) begin
         if (i < 5) drive(1, 2'd0, 7, 7, sat);
         else       drive(0, 2'd0, 0, 0, 0);
         tick();
         if (i >= 1 && i <= 5) begin
            exp_v = model_out();
            got   = {o_data, o_overflow, o_count, o_valid};
            checks++;
            if (got !== exp_v || o_data !== NB_ACC'(expd[i-1]) || o_valid !== 1'b1
                || o_overflow !== (i == 5)) begin
               failures++;
               $display("FAIL b2b_sat%0b_%0d: data=%0d ovf=%0b cnt=%0d vld=%0b expected data=%0d ovf=%0b cnt=%0d vld=1",
                        sat, i, o_data, o_overflow, o_count, o_valid, expd[i-1], (i == 5), i);
            end
         end
      end
      checks++;
      if (o_valid !== 1'b0 || o_count !== 8'd5) begin
         failures++;
         $display("FAIL b2b_sat%0b_end: vld=%0b cnt=%0d expected vld=0 cnt=5", sat, o_valid, o_count);
      end
      if (sat) begin
         drive(1, 2'd1, 1, 0, 1);
         tick();
         drive(0, 2'd0, 0, 0, 0);
         tick();
         checks++;
         if (o_data !== 6'd63 || o_overflow !== 1'b1 || o_count !== 8'd6 || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL sat_hold: data=%0d ovf=%0b cnt=%0d vld=%0b expected data=63 ovf=1 cnt=6 vld=1", o_data, o_overflow, o_count, o_valid);
         end
      end
   endtask

   task automatic test_exact_landing();
      do_clear();
      for (int i = 0; i < 4; i++) begin
         drive(1, 2'd0, 7, 7, 1);
         tick();
      end
      drive(1, 2'd1, 4, 0, 1);
      tick();
      drive(1, 2'd2, 5, 3, 1);
      tick();
      drive(1, 2'd3, 7, 7, 1);
      tick();
      checks++;
      if (o_data !== 6'd63 || o_overflow !== 1'b0 || o_valid !== 1'b1) begin
         failures++;
         $display("FAIL exact_landing: data=%0d ovf=%0b vld=%0b expected data=63 ovf=0 vld=1", o_data, o_overflow, o_valid);
      end
      drive(0, 2'd0, 0, 0, 0);
      tick();
      got = {o_data, o_overflow, o_count, o_valid};
      checks++;
      if (got !== {6'd63, 1'b0, 8'd7, 1'b1} || got !== model_out()) begin
         failures++;
         $display("FAIL sel11_sample: data=%0d ovf=%0b cnt=%0d vld=%0b expected data=63 ovf=0 cnt=7 vld=1", o_data, o_overflow, o_count, o_valid);
      end
   endtask

   task automatic test_clear_inflight();
      do_clear();
      for (int i = 0; i < 7; i++) begin
         drive(1, 2'd0, 7, 7, 0);
         tick();
      end
      drive(1, 2'd0, 7, 1, 0);
      tick();
      drive(1, 2'd1, 5, 0, 0);
      tick();
      checks++;
      if (o_data !== 6'd42 || o_overflow !== 1'b1) begin
         failures++;
         $display("FAIL clear_setup: data=%0d ovf=%0b expected data=42 ovf=1", o_data, o_overflow);
      end
      drive(1, 2'd0, 7, 7, 0);
      i_clear = 1;
      tick();
      i_clear = 0;
      drive(0, 2'd0, 0, 0, 0);
      checks++;
      if ({o_data, o_overflow, o_count, o_valid} !== '0) begin
         failures++;
         $display("FAIL clear_edge: data=%0d ovf=%0b cnt=%0d vld=%0b expected all zero", o_data, o_overflow, o_count, o_valid);
      end
      tick();
      checks++;
      if ({o_data, o_overflow, o_count, o_valid} !== '0 || model_out() !== '0) begin
         failures++;
         $display("FAIL clear_flush: data=%0d ovf=%0b cnt=%0d vld=%0b expected all zero", o_data, o_overflow, o_count, o_valid);
      end
   endtask

   task automatic test_count_sat_and_reset();
      do_clear();
      drive(1, 2'd3, 0, 0, 0);
      for (int i = 0; i < 262; i++) begin
         tick();
         exp_v = model_out();
         got   = {o_data, o_overflow, o_count, o_valid};
         if (i == 10 || i == 200 || i >= 253) begin
            checks++;
            if (got !== exp_v) begin
               failures++;
               $display("FAIL count_%0d: data=%0d ovf=%0b cnt=%0d vld=%0b expected cnt=%0d vld=%0b",
                        i, o_data, o_overflow, o_count, o_valid, m_cnt, m_vld);
            end
         end
      end
      checks++;
      if (o_count !== 8'd255) begin
         failures++;
         $display("FAIL count_sat: cnt=%0d expected 255", o_count);
      end
      // Raise reset between edges while a sample sits in stage 1.
      #2;
      i_rst = 1;
      #1;
      model_reset();
      checks++;
      if ({o_data, o_overflow, o_count, o_valid} !== '0) begin
         failures++;
         $display("FAIL async_reset: data=%0d ovf=%0b cnt=%0d vld=%0b expected all zero", o_data, o_overflow, o_count, o_valid);
      end
      drive(0, 2'd0, 0, 0, 0);
      repeat (2) @(posedge clock);
      #1;
      i_rst = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({o_data, o_overflow, o_count, o_valid} !== '0) begin
            failures++;
            $display("FAIL post_reset_%0d: data=%0d ovf=%0b cnt=%0d vld=%0b expected all zero", i, o_data, o_overflow, o_count, o_valid);
         end
      end
   endtask

   task automatic test_random();
      do_clear();
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         i_clear = ($urandom_range(0, 59) == 0);
         tick();
         exp_v = model_out();
         got   = {o_data, o_overflow, o_count, o_valid};
         checks++;
         if (got !== exp_v) begin
            failures++;
            $display("FAIL random_%0d: data=%0d ovf=%0b cnt=%0d vld=%0b expected data=%0d ovf=%0b cnt=%0d vld=%0b",
                     i, o_data, o_overflow, o_count, o_valid, m_acc, m_ov, m_cnt, m_vld);
         end
      end
      i_clear = 0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_back_to_back(0);
      test_back_to_back(1);
      test_exact_landing();
      test_clear_inflight();
      test_count_sat_and_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
